// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-request APB requester with slave decode and wait-state timeout
module apb_master_bridge #(
  parameter int NUM_SLAVES  = 2,
  parameter int SLV_SEL_LSB = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic                     p_clk,
  input  logic                     p_reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  input  logic [3:0]               req_strb,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic [31:0]              p_addr,
  output logic [NUM_SLAVES-1:0]    p_sel,
  output logic [NUM_SLAVES-1:0]    p_enable,
  output logic                     p_write,
  output logic [31:0]              p_wdata,
  output logic [3:0]               p_strb,
  input  logic [NUM_SLAVES*32-1:0] p_rdata,
  input  logic [NUM_SLAVES-1:0]    p_ready,
  input  logic [NUM_SLAVES-1:0]    p_slverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [3:0] idx, req_idx;
  logic [NUM_SLAVES-1:0] onehot;
  logic [31:0] sel_rdata;
  logic sel_ready, sel_err, accept, decode_ok, timeout;
  assign req_idx   = req_addr[SLV_SEL_LSB+3:SLV_SEL_LSB];
  assign decode_ok = {28'd0, req_idx} < NUM_SLAVES;
  assign req_ready = (state == IDLE) && !p_reset;
  assign accept    = req_valid && req_ready;
  assign onehot    = NUM_SLAVES'(1) << idx;
  assign timeout   = cnt == CW'(TIMEOUT - 1);
  assign sel_ready = |(p_ready & onehot);
  assign sel_err   = |(p_slverr & onehot);
  assign p_sel     = (state == SETUP || state == ACCESS) ? onehot : '0;
  assign p_enable  = (state == ACCESS) ? onehot : '0;
  assign rsp_valid = state == RESP;
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (onehot[i]) sel_rdata = p_rdata[32*i +: 32];
  end
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? (decode_ok ? SETUP : RESP) : IDLE;
      SETUP:   state_next = ACCESS;
      ACCESS:  state_next = (sel_ready || timeout) ? RESP : ACCESS;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      p_addr    <= '0;
      p_write   <= 1'b0;
      p_wdata   <= '0;
      p_strb    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= (state == ACCESS) ? cnt + CW'(1) : '0;
      if (accept) begin
        idx     <= req_idx;
        p_addr  <= req_addr;
        p_write <= req_write;
        p_wdata <= req_wdata;
        p_strb  <= req_write ? req_strb : 4'b0000;
        if (!decode_ok) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
      // ready wins over timeout when both land in the final ACCESS cycle
      if (state == ACCESS && sel_ready) begin
        rsp_rdata <= p_write ? 32'd0 : sel_rdata;
        rsp_err   <= sel_err;
      end else if (state == ACCESS && timeout) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed scenario checks for apb_master_bridge
module tb_apb_master_bridge;
  logic p_clk = 1'b0;
  logic p_reset = 1'b1;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_strb = '0;
  logic rsp_valid, rsp_err, p_write;
  logic [31:0] rsp_rdata, p_addr, p_wdata;
  logic [1:0] p_sel, p_enable;
  logic [3:0] p_strb;
  logic [63:0] p_rdata = '0;
  logic [1:0] p_ready = '0, p_slverr = '0;
  int checks = 0, failures = 0;

  apb_master_bridge #(.NUM_SLAVES(2), .SLV_SEL_LSB(8), .TIMEOUT(16)) dut (
    .p_clk(p_clk), .p_reset(p_reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .p_addr(p_addr),
    .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write), .p_wdata(p_wdata), .p_strb(p_strb),
    .p_rdata(p_rdata), .p_ready(p_ready), .p_slverr(p_slverr)
  );

  always #5 p_clk = ~p_clk;

  // presents a request for one cycle; returns at the negedge of the SETUP cycle
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge p_clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL send_ready got=%b exp=1", req_ready); end
    @(negedge p_clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    p_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge p_clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_err, p_sel, p_enable, p_write, p_strb, p_addr, p_wdata, rsp_rdata} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d ready=%b rsp=%b err=%b sel=%b en=%b addr=%h rdata=%h exp all 0",
                 i, req_ready, rsp_valid, rsp_err, p_sel, p_enable, p_addr, rsp_rdata);
      end
    end
    p_reset = 1'b0;
    @(negedge p_clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_write;
    p_ready = 2'b01; p_slverr = 2'b00;
    send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if ({p_sel, p_enable, p_addr, p_write, p_wdata, p_strb} !== {2'b01, 2'b00, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
      failures++;
      $display("FAIL write_setup sel=%b en=%b addr=%h wr=%b wdata=%h strb=%h exp 01 00 10 1 deadbeef f",
               p_sel, p_enable, p_addr, p_write, p_wdata, p_strb);
    end
    @(negedge p_clk);
    checks++;
    if ({p_sel, p_enable, rsp_valid} !== {2'b01, 2'b01, 1'b0}) begin
      failures++; $display("FAIL write_access sel=%b en=%b rsp=%b exp 01 01 0", p_sel, p_enable, rsp_valid);
    end
    @(negedge p_clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, p_sel, p_enable} !== {1'b1, 1'b0, 32'd0, 2'b00, 2'b00}) begin
      failures++; $display("FAIL write_resp rsp=%b err=%b rdata=%h sel=%b en=%b exp 1 0 0 00 00",
                           rsp_valid, rsp_err, rsp_rdata, p_sel, p_enable);
    end
    @(negedge p_clk);
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      failures++; $display("FAIL write_idle ready=%b rsp=%b exp 1 0", req_ready, rsp_valid);
    end
    p_ready = 2'b00;
  endtask

  task automatic test_read_wait;
    p_rdata = {32'h0000_00A5, 32'h1234_5678};
    p_ready = 2'b01; p_slverr = 2'b01;
    send(1'b0, 32'h0000_0110, 32'h5555_5555, 4'hF);
    checks++;
    if ({p_sel, p_enable, p_strb, p_write} !== {2'b10, 2'b00, 4'h0, 1'b0}) begin
      failures++; $display("FAIL read_setup sel=%b en=%b strb=%h wr=%b exp 10 00 0 0", p_sel, p_enable, p_strb, p_write);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge p_clk);
      checks++;
      if ({p_sel, p_enable, p_strb, rsp_valid} !== {2'b10, 2'b10, 4'h0, 1'b0}) begin
        failures++; $display("FAIL read_access cycle=%0d sel=%b en=%b strb=%h rsp=%b exp 10 10 0 0",
                             i, p_sel, p_enable, p_strb, rsp_valid);
      end
      if (i == 2) p_ready = 2'b11;
    end
    @(negedge p_clk);
    p_ready = 2'b00; p_slverr = 2'b00;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0000_00A5}) begin
      failures++; $display("FAIL read_resp rsp=%b err=%b rdata=%h exp 1 0 000000a5", rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge p_clk);
    checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b0, 32'h0000_00A5}) begin
      failures++; $display("FAIL read_hold rsp=%b rdata=%h exp 0 000000a5", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_decode_err;
    @(negedge p_clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0200;
    @(negedge p_clk);
    req_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, p_sel, p_enable} !== {1'b1, 1'b1, 32'd0, 2'b00, 2'b00}) begin
      failures++; $display("FAIL decode_resp rsp=%b err=%b rdata=%h sel=%b en=%b exp 1 1 0 00 00",
                           rsp_valid, rsp_err, rsp_rdata, p_sel, p_enable);
    end
    @(negedge p_clk);
    checks++;
    if ({req_ready, p_sel} !== {1'b1, 2'b00}) begin
      failures++; $display("FAIL decode_idle ready=%b sel=%b exp 1 00", req_ready, p_sel);
    end
  endtask

  task automatic test_timeout;
    int en_cycles = 0;
    bit done = 1'b0;
    p_ready = 2'b00; p_rdata = {32'h1111_1111, 32'h7777_7777};
    send(1'b0, 32'h0000_0004, 32'd0, 4'h0);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge p_clk);
      if (rsp_valid) done = 1'b1;
      else if (p_enable == 2'b01) en_cycles++;
    end
    checks++;
    if (!done) begin failures++; $display("FAIL timeout_no_resp got=none exp rsp_valid within 40 cycles"); end
    checks++;
    if (en_cycles != 16) begin failures++; $display("FAIL timeout_enable_cycles got=%0d exp=16", en_cycles); end
    checks++;
    if ({rsp_err, rsp_rdata, p_sel, p_enable} !== {1'b1, 32'd0, 2'b00, 2'b00}) begin
      failures++; $display("FAIL timeout_resp err=%b rdata=%h sel=%b en=%b exp 1 0 00 00", rsp_err, rsp_rdata, p_sel, p_enable);
    end
  endtask

  task automatic test_ready_at_limit;
    p_ready = 2'b00;
    send(1'b0, 32'h0000_0104, 32'd0, 4'h0);
    for (int i = 0; i < 16; i++) @(negedge p_clk);
    p_ready = 2'b10;
    @(negedge p_clk);
    p_ready = 2'b00;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h1111_1111}) begin
      failures++; $display("FAIL limit_ready rsp=%b err=%b rdata=%h exp 1 0 11111111", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_slverr;
    p_ready = 2'b10; p_slverr = 2'b10;
    send(1'b1, 32'h0000_0120, 32'hA5A5_0000, 4'h3);
    @(negedge p_clk);
    @(negedge p_clk);
    p_ready = 2'b00; p_slverr = 2'b00;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'd0}) begin
      failures++; $display("FAIL slverr_resp rsp=%b err=%b rdata=%h exp 1 1 0", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid;
    p_ready = 2'b00;
    send(1'b0, 32'h0000_0008, 32'd0, 4'h0);
    @(negedge p_clk);
    checks++;
    if (p_enable !== 2'b01) begin failures++; $display("FAIL midrst_access en=%b exp 01", p_enable); end
    p_reset = 1'b1;
    @(negedge p_clk);
    checks++;
    if ({p_sel, p_enable, rsp_valid, req_ready} !== 6'b0) begin
      failures++; $display("FAIL midrst_abort sel=%b en=%b rsp=%b ready=%b exp 00 00 0 0", p_sel, p_enable, rsp_valid, req_ready);
    end
    p_reset = 1'b0;
    @(negedge p_clk);
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      failures++; $display("FAIL midrst_idle rsp=%b ready=%b exp 0 1", rsp_valid, req_ready);
    end
    p_ready = 2'b01; p_rdata = {32'h0, 32'hCAFE_0001};
    send(1'b0, 32'h0000_0008, 32'd0, 4'h0);
    @(negedge p_clk);
    @(negedge p_clk);
    p_ready = 2'b00;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hCAFE_0001}) begin
      failures++; $display("FAIL midrst_next rsp=%b err=%b rdata=%h exp 1 0 cafe0001", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read_wait;
    test_decode_err;
    test_timeout;
    test_ready_at_limit;
    test_slverr;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
